// File: rtl/mcpu_mc_pkg.sv
// mcpu_mc_pkg: shared widths and arbiter state encoding for the MCPU memory-controller slice.
package mcpu_mc_pkg;
   localparam int MC_ADDR_W = 25;
   localparam int MC_DATA_W = 128;
   localparam int MC_SIZE_W = 5;
   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_WBURST = 1'b1;
endpackage

// File: rtl/mcpu_mc_arb_rdq.sv
// mcpu_mc_arb_rdq: in-order FIFO of {id,size} tags for outstanding read bursts, with full/empty flags.
module mcpu_mc_arb_rdq #(
   parameter int DEPTH  = 8,
   parameter int ID_W   = 1,
   parameter int SIZE_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [ID_W-1:0]   push_id,
   input  logic [SIZE_W-1:0] push_size,
   input  logic              pop,
   output logic [ID_W-1:0]   head_id,
   output logic [SIZE_W-1:0] head_size,
   output logic              full,
   output logic              empty
);
   localparam int AW = $clog2(DEPTH);
   logic [ID_W+SIZE_W-1:0] mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic do_push, do_pop;
   always_comb begin
      empty = wr_ptr_q == rd_ptr_q;
      full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      do_pop = pop & !empty;
      do_push = push & (!full | do_pop);
      wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
      rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
      {head_id, head_size} = mem_q[rd_ptr_q[AW-1:0]];
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   always_ff @(posedge clk)
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= {push_id, push_size};
endmodule

// File: rtl/mcpu_mc_arb.sv
// mcpu_mc_arb: round-robin arbiter sharing one MC Avalon port between NREQ requesters, with write-burst lock.
// Define MCPU_MC_ARB_STATS_EN to add stat_grants, per-requester saturating command counters.
module mcpu_mc_arb
   import mcpu_mc_pkg::*;
#(
   parameter int NREQ      = 2,
   parameter int RDQ_DEPTH = 8,
   parameter int ADDR_W    = MC_ADDR_W,
   parameter int DATA_W    = MC_DATA_W,
   parameter int SIZE_W    = MC_SIZE_W
) (
   input  logic                       clkrst_mem_clk,
   input  logic                       clkrst_mem_rst_n,
   input  logic [NREQ*ADDR_W-1:0]     req_addr,
   input  logic [NREQ*(DATA_W/8)-1:0] req_be,
   input  logic [NREQ*DATA_W-1:0]     req_wdata,
   input  logic [NREQ*SIZE_W-1:0]     req_size,
   input  logic [NREQ-1:0]            req_burstbegin,
   input  logic [NREQ-1:0]            req_read,
   input  logic [NREQ-1:0]            req_write,
   output logic [NREQ-1:0]            req_ready,
   output logic [DATA_W-1:0]          req_rdata,
   output logic [NREQ-1:0]            req_rdata_valid,
   output logic [ADDR_W-1:0]          mc_addr,
   output logic [DATA_W/8-1:0]        mc_be,
   output logic [DATA_W-1:0]          mc_wdata,
   output logic [SIZE_W-1:0]          mc_size,
   output logic                       mc_burstbegin,
   output logic                       mc_read,
   output logic                       mc_write,
   input  logic                       mc_ready,
   input  logic [DATA_W-1:0]          mc_rdata,
   input  logic                       mc_rdata_valid,
   output logic                       arb_err
`ifdef MCPU_MC_ARB_STATS_EN
   ,
   output logic [NREQ*16-1:0]         stat_grants
`endif
);
   localparam int ID_W = $clog2(NREQ);
   localparam int BE_W = DATA_W/8;
   logic [0:0] state_q, state_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d, owner_q, owner_d, gnt, nxt_ptr, head_id;
   logic [SIZE_W-1:0] beats_left_q, beats_left_d, cnt_q, cnt_d, head_size, eff_size;
   logic arb_err_q, arb_err_d;
   logic [NREQ-1:0] elig;
   logic gnt_v, wburst, accept, cmd_acc, push, pop, ret, rdq_full, rdq_empty;
   // Reads are only eligible while the tag queue has room, so a blocked read yields to a write.
   always_comb begin
      wburst = state_q == ST_WBURST;
      elig = req_write | (req_read & {NREQ{!rdq_full}});
      gnt = rr_ptr_q;
      gnt_v = 1'b0;
      for (int k = NREQ-1; k >= 0; k--)
         if (elig[(int'(rr_ptr_q) + k) % NREQ]) begin
            gnt = ID_W'((int'(rr_ptr_q) + k) % NREQ);
            gnt_v = 1'b1;
         end
      if (wburst) begin
         gnt = owner_q;
         gnt_v = 1'b1;
      end
      mc_addr = req_addr[gnt*ADDR_W +: ADDR_W];
      mc_be = req_be[gnt*BE_W +: BE_W];
      mc_wdata = req_wdata[gnt*DATA_W +: DATA_W];
      mc_size = req_size[gnt*SIZE_W +: SIZE_W];
      mc_write = gnt_v & req_write[gnt];
      mc_read = gnt_v & !wburst & !req_write[gnt] & req_read[gnt];
      mc_burstbegin = gnt_v & !wburst & req_burstbegin[gnt];
      accept = mc_ready & (mc_read | mc_write);
      req_ready = '0;
      req_ready[gnt] = accept;
      cmd_acc = accept & !wburst;
      eff_size = (mc_size == '0) ? SIZE_W'(1) : mc_size;
      push = cmd_acc & mc_read;
      nxt_ptr = (int'(gnt) == NREQ-1) ? '0 : gnt + ID_W'(1);
      state_d = state_q;
      owner_d = owner_q;
      beats_left_d = beats_left_q;
      rr_ptr_d = rr_ptr_q;
      if (wburst) begin
         if (accept) begin
            beats_left_d = beats_left_q - SIZE_W'(1);
            if (beats_left_q == SIZE_W'(1)) begin
               state_d = ST_IDLE;
               rr_ptr_d = nxt_ptr;
            end
         end
      end else if (cmd_acc) begin
         if (mc_write && eff_size != SIZE_W'(1)) begin
            state_d = ST_WBURST;
            owner_d = gnt;
            beats_left_d = eff_size - SIZE_W'(1);
         end else begin
            rr_ptr_d = nxt_ptr;
         end
      end
      ret = mc_rdata_valid & !rdq_empty;
      req_rdata = mc_rdata;
      req_rdata_valid = '0;
      req_rdata_valid[head_id] = ret;
      pop = ret & (cnt_q + SIZE_W'(1) == head_size);
      cnt_d = ret ? (pop ? '0 : cnt_q + SIZE_W'(1)) : cnt_q;
      arb_err_d = arb_err_q | (mc_rdata_valid & rdq_empty) | (cmd_acc & (mc_size == '0));
      arb_err = arb_err_q;
   end
   always_ff @(posedge clkrst_mem_clk or negedge clkrst_mem_rst_n)
      if (!clkrst_mem_rst_n) begin
         state_q <= ST_IDLE;
         rr_ptr_q <= '0;
         owner_q <= '0;
         beats_left_q <= '0;
         cnt_q <= '0;
         arb_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q <= owner_d;
         beats_left_q <= beats_left_d;
         cnt_q <= cnt_d;
         arb_err_q <= arb_err_d;
      end
   mcpu_mc_arb_rdq #(.DEPTH(RDQ_DEPTH), .ID_W(ID_W), .SIZE_W(SIZE_W)) u_rdq (
      .clk(clkrst_mem_clk),
      .rst_n(clkrst_mem_rst_n),
      .push(push),
      .push_id(gnt),
      .push_size(eff_size),
      .pop(pop),
      .head_id(head_id),
      .head_size(head_size),
      .full(rdq_full),
      .empty(rdq_empty)
   );
`ifdef MCPU_MC_ARB_STATS_EN
   logic [15:0] stat_q [NREQ];
   logic [15:0] stat_d [NREQ];
   always_comb
      for (int i = 0; i < NREQ; i++) begin
         stat_d[i] = (cmd_acc && int'(gnt) == i && stat_q[i] != 16'hffff) ? stat_q[i] + 16'd1 : stat_q[i];
         stat_grants[i*16 +: 16] = stat_q[i];
      end
   always_ff @(posedge clkrst_mem_clk or negedge clkrst_mem_rst_n)
      if (!clkrst_mem_rst_n)
         for (int i = 0; i < NREQ; i++) stat_q[i] <= '0;
      else
         for (int i = 0; i < NREQ; i++) stat_q[i] <= stat_d[i];
`endif
endmodule
